// File: rtl/sample_window.sv
//------------------------------------------------------------------------------
// sample_window
//
// Sliding window of the most recent WINDOW_SIZE signed samples, kept in a
// circular buffer. For every accepted sample the block presents the sample
// entering the window (first) and the sample it displaces (last). A
// downstream accumulator can keep a running window statistic from these
// values, for example energy = sum(first^2 - last^2).
//
// Parameters
//   WINDOW_SIZE  : number of samples in the window (2..1024)
//   DATA_WIDTH   : sample width in bits, signed two's complement
//
// Ports
//   clock        : rising-edge clock for all state
//   reset        : synchronous, active-high reset
//   flush        : synchronous window clear, same effect as reset
//   sample_in    : incoming signed sample
//   sample_valid : sample_in is accepted on this edge
//   first        : registered copy of the sample entering the window
//   last         : registered copy of the sample leaving the window
//                  (0 while the window is still filling)
//   update       : one-cycle strobe, first/last refreshed this cycle
//   window_full  : high once WINDOW_SIZE samples have been accepted
//   fill_count   : samples currently held, saturating at WINDOW_SIZE
//------------------------------------------------------------------------------
module sample_window #(
   parameter int WINDOW_SIZE = 15,
   parameter int DATA_WIDTH  = 16,
   localparam int COUNT_WIDTH = $clog2(WINDOW_SIZE + 1),
   localparam int PTR_WIDTH   = (WINDOW_SIZE > 2) ? $clog2(WINDOW_SIZE) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [DATA_WIDTH-1:0]  sample_in,
   input  logic                   sample_valid,
   output logic [DATA_WIDTH-1:0]  first,
   output logic [DATA_WIDTH-1:0]  last,
   output logic                   update,
   output logic                   window_full,
   output logic [COUNT_WIDTH-1:0] fill_count
);

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                  state;
   logic [PTR_WIDTH-1:0]    wr_ptr;
   logic [DATA_WIDTH-1:0]   buffer [WINDOW_SIZE];

   // Single sequential block: FSM, pointer, buffer and registered outputs.
   // The buffer entry at wr_ptr is read into last on the same edge that it
   // is overwritten, so last is always the sample from WINDOW_SIZE
   // acceptances ago. While filling, the slot being overwritten holds no
   // sample of the current window, so last is forced to 0 instead.
   // reset and flush both clear every entry so a fresh fill never sees
   // stale data from an earlier window.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         state       <= FILL;
         wr_ptr      <= '0;
         first       <= '0;
         last        <= '0;
         update      <= 1'b0;
         window_full <= 1'b0;
         fill_count  <= '0;
         for (int i = 0; i < WINDOW_SIZE; i++) begin
            buffer[i] <= '0;
         end
      end else begin
         update <= 1'b0;
         if (sample_valid) begin
            update         <= 1'b1;
            first          <= sample_in;
            buffer[wr_ptr] <= sample_in;
            if (wr_ptr == PTR_WIDTH'(WINDOW_SIZE - 1)) begin
               wr_ptr <= '0;
            end else begin
               wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (state == FILL) begin
               last       <= '0;
               fill_count <= fill_count + COUNT_WIDTH'(1);
               if (fill_count == COUNT_WIDTH'(WINDOW_SIZE - 1)) begin
                  state       <= RUN;
                  window_full <= 1'b1;
               end
            end else begin
               last <= buffer[wr_ptr];
            end
         end
      end
   end

endmodule

// File: tb/tb_sample_window.sv
//------------------------------------------------------------------------------
// tb_sample_window
//
// Directed vector table against a WINDOW_SIZE=4 instance (fill, steady
// state, gapped extreme values, flush and reset mid-run, pointer wrap),
// followed by a random energy scoreboard against WINDOW_SIZE=15 and
// WINDOW_SIZE=2 instances sharing the same input stream.
//------------------------------------------------------------------------------
module tb_sample_window;

   logic        clock;
   logic        reset;
   logic        flush;
   logic [15:0] sample_in;
   logic        sample_valid;

   logic [15:0] first4, last4;
   logic        update4, full4;
   logic [2:0]  count4;

   logic [15:0] first15, last15;
   logic        update15, full15;
   logic [3:0]  count15;

   logic [15:0] first2, last2;
   logic        update2, full2;
   logic [1:0]  count2;

   int nVectors;
   int nMiscompares;

   sample_window #(.WINDOW_SIZE(4), .DATA_WIDTH(16)) dut4 (
      .clock(clock), .reset(reset), .flush(flush),
      .sample_in(sample_in), .sample_valid(sample_valid),
      .first(first4), .last(last4), .update(update4),
      .window_full(full4), .fill_count(count4)
   );

   sample_window #(.WINDOW_SIZE(15), .DATA_WIDTH(16)) dut15 (
      .clock(clock), .reset(reset), .flush(flush),
      .sample_in(sample_in), .sample_valid(sample_valid),
      .first(first15), .last(last15), .update(update15),
      .window_full(full15), .fill_count(count15)
   );

   sample_window #(.WINDOW_SIZE(2), .DATA_WIDTH(16)) dut2 (
      .clock(clock), .reset(reset), .flush(flush),
      .sample_in(sample_in), .sample_valid(sample_valid),
      .first(first2), .last(last2), .update(update2),
      .window_full(full2), .fill_count(count2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        fl;
      logic        valid;
      logic [15:0] sample;
      logic        expUpdate;
      logic [15:0] expFirst;
      logic [15:0] expLast;
      logic        expFull;
      logic [2:0]  expCount;
   } vector_t;

   vector_t table4[$];

   // Queue one directed vector.
   task automatic addVec(input logic rst, input logic fl, input logic valid,
                         input logic [15:0] sample, input logic expUpdate,
                         input logic [15:0] expFirst, input logic [15:0] expLast,
                         input logic expFull, input logic [2:0] expCount);
      vector_t v;
      v.rst = rst; v.fl = fl; v.valid = valid; v.sample = sample;
      v.expUpdate = expUpdate; v.expFirst = expFirst; v.expLast = expLast;
      v.expFull = expFull; v.expCount = expCount;
      table4.push_back(v);
   endtask

   // Drive one vector between edges, then let one rising edge take it.
   task automatic applyStimulus(input vector_t v);
      @(negedge clock);
      reset        = v.rst;
      flush        = v.fl;
      sample_valid = v.valid;
      sample_in    = v.sample;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input int idx, input vector_t v);
      nVectors++;
      if (update4 !== v.expUpdate || first4 !== v.expFirst || last4 !== v.expLast ||
          full4 !== v.expFull || count4 !== v.expCount) begin
         nMiscompares++;
         $display("[TB] FAIL vec%0d: got upd=%b first=%h last=%h full=%b cnt=%0d, want upd=%b first=%h last=%h full=%b cnt=%0d",
                  idx, update4, first4, last4, full4, count4,
                  v.expUpdate, v.expFirst, v.expLast, v.expFull, v.expCount);
      end
   endtask

   // Energy scoreboard state.
   longint hist15[$];
   longint hist2[$];
   longint acc15, acc2;

   function automatic longint sumSquares(input longint q[$]);
      longint s;
      s = 0;
      foreach (q[i]) s += q[i] * q[i];
      return s;
   endfunction

   task automatic checkEnergy(input string name, input logic upd, input logic expUpd,
                              input longint acc, input longint expAcc);
      nVectors++;
      if (upd !== expUpd || (expUpd && acc != expAcc)) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got update=%b energy=%0d, want update=%b energy=%0d",
                  name, upd, acc, expUpd, expAcc);
      end
   endtask

   initial begin
      logic [15:0] s;
      logic        v;
      longint      f, l;

      nVectors     = 0;
      nMiscompares = 0;
      reset        = 1'b1;
      flush        = 1'b0;
      sample_valid = 1'b0;
      sample_in    = '0;

      // Reset state, with a sample offered during reset that must be ignored.
      addVec(1, 0, 1, 16'd55, 0, 16'd0, 16'd0, 0, 3'd0);
      addVec(0, 0, 0, 16'd0,  0, 16'd0, 16'd0, 0, 3'd0);
      // Fill 1..4.
      addVec(0, 0, 1, 16'd1, 1, 16'd1, 16'd0, 0, 3'd1);
      addVec(0, 0, 1, 16'd2, 1, 16'd2, 16'd0, 0, 3'd2);
      addVec(0, 0, 1, 16'd3, 1, 16'd3, 16'd0, 0, 3'd3);
      addVec(0, 0, 1, 16'd4, 1, 16'd4, 16'd0, 1, 3'd4);
      // Steady state 5, 6, -7.
      addVec(0, 0, 1, 16'd5,     1, 16'd5,     16'd1, 1, 3'd4);
      addVec(0, 0, 1, 16'd6,     1, 16'd6,     16'd2, 1, 3'd4);
      addVec(0, 0, 1, 16'hFFF9,  1, 16'hFFF9,  16'd3, 1, 3'd4);
      // Idle: outputs hold.
      addVec(0, 0, 0, 16'd42,    0, 16'hFFF9,  16'd3, 1, 3'd4);
      // Flush together with sample 99: discarded, everything cleared.
      addVec(0, 1, 1, 16'd99,    0, 16'd0, 16'd0, 0, 3'd0);
      addVec(0, 0, 1, 16'd5,     1, 16'd5, 16'd0, 0, 3'd1);
      addVec(0, 1, 0, 16'd0,     0, 16'd0, 16'd0, 0, 3'd0);
      // Gapped extremes: a sample every third cycle.
      for (int i = 0; i < 6; i++) begin
         logic [15:0] sv, lv;
         logic [2:0]  c;
         sv = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
         lv = (i < 4) ? 16'h0000 : ((i % 2 == 0) ? 16'h7FFF : 16'h8000);
         c  = (i < 4) ? 3'(i + 1) : 3'd4;
         addVec(0, 0, 1, sv,    1, sv, lv, (i >= 3), c);
         addVec(0, 0, 0, 16'd0, 0, sv, lv, (i >= 3), c);
         addVec(0, 0, 0, 16'd0, 0, sv, lv, (i >= 3), c);
      end
      // Pointer wrap after a flush: 10..19, stale data must not appear.
      addVec(0, 1, 0, 16'd0, 0, 16'd0, 16'd0, 0, 3'd0);
      for (int i = 0; i < 10; i++) begin
         addVec(0, 0, 1, 16'(10 + i), 1, 16'(10 + i),
                (i < 4) ? 16'd0 : 16'(10 + i - 4), (i >= 3),
                (i < 4) ? 3'(i + 1) : 3'd4);
      end
      // Reset mid-run with a sample offered, then a fresh first sample.
      addVec(1, 0, 1, 16'd77, 0, 16'd0, 16'd0, 0, 3'd0);
      addVec(0, 0, 1, 16'd7,  1, 16'd7, 16'd0, 0, 3'd1);
      addVec(0, 0, 0, 16'd0,  0, 16'd7, 16'd0, 0, 3'd1);

      foreach (table4[i]) begin
         applyStimulus(table4[i]);
         checkOutput(i, table4[i]);
      end

      // Random energy scoreboard for WINDOW_SIZE 15 and 2.
      @(negedge clock);
      reset        = 1'b1;
      flush        = 1'b0;
      sample_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      acc15 = 0;
      acc2  = 0;
      for (int n = 0; n < 1000; n++) begin
         v = ($urandom_range(0, 3) != 0);
         s = 16'($urandom);
         if (n % 97 == 0) s = 16'h8000;
         if (n % 89 == 0) s = 16'h7FFF;
         @(negedge clock);
         sample_valid = v;
         sample_in    = s;
         if (v) begin
            hist15.push_back(longint'($signed(s)));
            hist2.push_back(longint'($signed(s)));
            if (hist15.size() > 15) void'(hist15.pop_front());
            if (hist2.size() > 2) void'(hist2.pop_front());
         end
         @(posedge clock);
         #1;
         if (update15) begin
            f = longint'($signed(first15));
            l = longint'($signed(last15));
            acc15 += f * f - l * l;
         end
         if (update2) begin
            f = longint'($signed(first2));
            l = longint'($signed(last2));
            acc2 += f * f - l * l;
         end
         checkEnergy("energy15", update15, v, acc15, sumSquares(hist15));
         checkEnergy("energy2",  update2,  v, acc2,  sumSquares(hist2));
      end
      @(negedge clock);
      sample_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
